iob2axi_wr_burst_ctrl: RTL and testbench

//  Sequencer in front of the iob2axi_wr AXI-4 write engine. Takes one DMA write job (start byte address,

---
 rtl/iob2axi_wr_burst_ctrl_if.sv | 44 ++++
 rtl/iob2axi_wr_burst_ctrl.sv | 152 +++++++++++++++
 tb/tb_iob2axi_wr_burst_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob2axi_wr_burst_ctrl_if.sv
// Bundle of the job, upstream stream and engine-side signals of the burst sequencer.
// master = the sequencer, slave = whatever sits around it (job source, data source, engine).
interface iob2axi_wr_burst_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8,
   parameter int CNT_W  = 16
);
   localparam int BYTES = DATA_W / 8;

   // job control
   logic              start;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  nwords;
   logic              busy;
   logic              done;
   logic              error;

   // upstream data stream
   logic              in_valid;
   logic [DATA_W-1:0] in_wdata;
   logic [BYTES-1:0]  in_wstrb;
   logic              in_ready;

   // write engine side
   logic [LEN_W-1:0]  wr_length;
   logic              wr_ready;
   logic              wr_error;
   logic              s_valid;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic [BYTES-1:0]  s_wstrb;
   logic              s_ready;

   modport master (
      input  start, addr, nwords, in_valid, in_wdata, in_wstrb, wr_ready, wr_error, s_ready,
      output busy, done, error, in_ready, wr_length, s_valid, s_addr, s_wdata, s_wstrb
   );

   modport slave (
      output start, addr, nwords, in_valid, in_wdata, in_wstrb, wr_ready, wr_error, s_ready,
      input  busy, done, error, in_ready, wr_length, s_valid, s_addr, s_wdata, s_wstrb
   );
endinterface

// File: rtl/iob2axi_wr_burst_ctrl.sv
// Burst sequencer in front of the iob2axi_wr engine: splits one DMA write job into
// INCR bursts of at most 2^LEN_W beats that never cross a 4 KB page, programs the
// engine per burst, forwards the data stream and accumulates burst errors.
module iob2axi_wr_burst_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8,
   parameter int CNT_W  = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   iob2axi_wr_burst_ctrl_if.master bus
);
   localparam int BYTES = DATA_W / 8;
   localparam int SHIFT = $clog2(BYTES);
   // wide enough for a full 4 KB page in words and the whole word count, plus a guard bit
   localparam int AW    = ((CNT_W > 13) ? CNT_W : 13) + 1;
   localparam int BW    = LEN_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CALC, S_ISSUE, S_DATA, S_RESP, S_DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
   logic [CNT_W-1:0]  remaining_reg, remaining_next;
   logic [BW-1:0]     beats_reg, beats_next;
   logic [BW-1:0]     beat_cnt_reg, beat_cnt_next;
   logic [LEN_W-1:0]  wr_length_reg, wr_length_next;
   logic [ADDR_W-1:0] s_addr_reg, s_addr_next;
   logic              busy_reg, busy_next;
   logic              error_reg, error_next;
   logic              s_valid_c, in_ready_c;

   logic [AW-1:0]     room, rem_ext, max_ext, beats_calc;

   // Size of the next burst: min(words left, max burst, words left in the 4 KB page)
   always_comb begin
      room       = (AW'(4096) - AW'(cur_addr_reg[11:0])) >> SHIFT;
      rem_ext    = AW'(remaining_reg);
      max_ext    = AW'(1) << LEN_W;
      beats_calc = rem_ext;
      if (max_ext < beats_calc) beats_calc = max_ext;
      if (room < beats_calc)    beats_calc = room;
   end

   // Next-state and output decode of the job/burst sequencer
   always_comb begin
      state_next     = state_reg;
      cur_addr_next  = cur_addr_reg;
      remaining_next = remaining_reg;
      beats_next     = beats_reg;
      beat_cnt_next  = beat_cnt_reg;
      wr_length_next = wr_length_reg;
      s_addr_next    = s_addr_reg;
      busy_next      = busy_reg;
      error_next     = error_reg;
      s_valid_c      = 1'b0;
      in_ready_c     = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (bus.start) begin
               error_next = 1'b0;
               if (bus.nwords != '0) begin
                  cur_addr_next  = bus.addr;
                  remaining_next = bus.nwords;
                  busy_next      = 1'b1;
                  state_next     = S_CALC;
               end else begin
                  // empty job: report completion without touching the engine
                  state_next = S_DONE;
               end
            end
         end
         S_CALC: begin
            beats_next     = beats_calc[BW-1:0];
            wr_length_next = LEN_W'(beats_calc - AW'(1));
            s_addr_next    = cur_addr_reg;
            beat_cnt_next  = '0;
            state_next     = S_ISSUE;
         end
         S_ISSUE: begin
            // single-cycle address kick; no data beat is consumed here
            if (bus.wr_ready) begin
               s_valid_c  = 1'b1;
               state_next = S_DATA;
            end
         end
         S_DATA: begin
            s_valid_c  = bus.in_valid;
            in_ready_c = bus.s_ready;
            if (bus.in_valid && bus.s_ready) begin
               if (beat_cnt_reg == beats_reg - BW'(1)) begin
                  beat_cnt_next = '0;
                  state_next    = S_RESP;
               end else begin
                  beat_cnt_next = beat_cnt_reg + BW'(1);
               end
            end
         end
         S_RESP: begin
            // engine raises wr_ready again once the burst response is in
            if (bus.wr_ready) begin
               error_next     = error_reg | bus.wr_error;
               cur_addr_next  = cur_addr_reg + (ADDR_W'(beats_reg) << SHIFT);
               remaining_next = remaining_reg - CNT_W'(beats_reg);
               state_next     = (remaining_reg == CNT_W'(beats_reg)) ? S_DONE : S_CALC;
            end
         end
         S_DONE: begin
            busy_next  = 1'b0;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously so no job survives reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         cur_addr_reg  <= '0;
         remaining_reg <= '0;
         beats_reg     <= '0;
         beat_cnt_reg  <= '0;
         wr_length_reg <= '0;
         s_addr_reg    <= '0;
         busy_reg      <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cur_addr_reg  <= cur_addr_next;
         remaining_reg <= remaining_next;
         beats_reg     <= beats_next;
         beat_cnt_reg  <= beat_cnt_next;
         wr_length_reg <= wr_length_next;
         s_addr_reg    <= s_addr_next;
         busy_reg      <= busy_next;
         error_reg     <= error_next;
      end
   end

   assign bus.busy      = busy_reg;
   assign bus.done      = (state_reg == S_DONE);
   assign bus.error     = error_reg;
   assign bus.in_ready  = in_ready_c;
   assign bus.s_valid   = s_valid_c;
   assign bus.wr_length = wr_length_reg;
   assign bus.s_addr    = s_addr_reg;
   assign bus.s_wdata   = bus.in_wdata;
   assign bus.s_wstrb   = bus.in_wstrb;
endmodule

// File: tb/tb_iob2axi_wr_burst_ctrl.sv
// Bench for the burst sequencer: a job driver, a random-rate upstream source and an
// engine model with random ready/response delays, checked through burst and data scoreboards.
module tb_iob2axi_wr_burst_ctrl;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;
   localparam int CNT_W  = 16;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  len;
   } burst_t;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  s;
   } word_t;

   logic clk = 1'b0;
   logic rst_n;

   iob2axi_wr_burst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

   iob2axi_wr_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   burst_t burst_q[$];
   word_t  src_q[$];
   word_t  exp_q[$];

   int e_state     = 0;   // 0 idle, 1 beats, 2 response wait
   int beats_left  = 0;
   int rsp_dly     = 0;
   int burst_idx   = 0;
   int err_burst   = -1;
   int beats_seen  = 0;
   bit seen_svalid = 1'b0;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic finish_test();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   // upstream source and engine model; drive at negedge, evaluate handshakes 1 time unit later
   initial begin
      bus.in_valid = 1'b0;
      bus.in_wdata = '0;
      bus.in_wstrb = '0;
      bus.wr_ready = 1'b0;
      bus.wr_error = 1'b0;
      bus.s_ready  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            e_state = 0;
            beats_left = 0;
            burst_q.delete();
            src_q.delete();
            exp_q.delete();
            bus.in_valid = 1'b0;
            bus.wr_ready = 1'b0;
            bus.wr_error = 1'b0;
            bus.s_ready  = 1'b0;
            continue;
         end
         case (e_state)
            0: begin
               bus.wr_ready = ($urandom_range(0, 2) != 0);
               bus.s_ready  = 1'b0;
            end
            1: begin
               bus.wr_ready = 1'b0;
               bus.wr_error = 1'b0;
               bus.s_ready  = ($urandom_range(0, 3) != 0);
            end
            default: begin
               bus.s_ready = 1'b0;
               if (rsp_dly == 0) begin
                  bus.wr_ready = 1'b1;
                  bus.wr_error = (burst_idx == err_burst);
                  burst_idx++;
                  e_state = 0;
               end else begin
                  bus.wr_ready = 1'b0;
                  rsp_dly--;
               end
            end
         endcase
         if (src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            bus.in_valid = 1'b1;
            bus.in_wdata = src_q[0].d;
            bus.in_wstrb = src_q[0].s;
         end else begin
            bus.in_valid = 1'b0;
            bus.in_wdata = $urandom;
            bus.in_wstrb = 4'($urandom);
         end
         #1;
         if (!rst_n) continue;
         if (bus.s_valid) seen_svalid = 1'b1;
         if (e_state == 0 && bus.s_valid) begin
            check_value("kick_in_ready", 64'(bus.in_ready), 64'd0);
            if (burst_q.size() == 0) begin
               check_value("kick_unexpected", 64'd1, 64'd0);
            end else begin
               burst_t b;
               b = burst_q.pop_front();
               check_value("s_addr", 64'(bus.s_addr), 64'(b.a));
               check_value("wr_length", 64'(bus.wr_length), 64'(b.len));
            end
            beats_left = int'(bus.wr_length) + 1;
            e_state = 1;
         end else if (e_state == 1 && bus.s_valid && bus.s_ready) begin
            check_value("in_ready", 64'(bus.in_ready), 64'd1);
            if (exp_q.size() == 0) begin
               check_value("beat_unexpected", 64'd1, 64'd0);
            end else begin
               word_t w;
               w = exp_q.pop_front();
               void'(src_q.pop_front());
               check_value("s_wdata", 64'(bus.s_wdata), 64'(w.d));
               check_value("s_wstrb", 64'(bus.s_wstrb), 64'(w.s));
            end
            beats_seen++;
            beats_left--;
            if (beats_left == 0) begin
               e_state = 2;
               rsp_dly = $urandom_range(0, 3);
            end
         end else if (e_state == 2 && bus.s_valid) begin
            check_value("s_valid_in_resp", 64'd1, 64'd0);
         end
      end
   end

   // build expected bursts and data for a job, then pulse start
   task automatic start_job(input logic [31:0] a0, input int n, input int eb);
      logic [31:0] a;
      int rem, room, b;
      a = a0;
      rem = n;
      while (rem > 0) begin
         burst_t bt;
         room = (4096 - int'(a[11:0])) / 4;
         b = rem;
         if (b > 256)  b = 256;
         if (b > room) b = room;
         bt.a = a;
         bt.len = 8'(b - 1);
         burst_q.push_back(bt);
         a = a + 32'(4 * b);
         rem -= b;
      end
      for (int i = 0; i < n; i++) begin
         word_t w;
         w.d = $urandom;
         w.s = 4'($urandom_range(0, 15));
         src_q.push_back(w);
         exp_q.push_back(w);
      end
      err_burst = eb;
      burst_idx = 0;
      seen_svalid = 1'b0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.addr   = a0;
      bus.nwords = 16'(n);
      @(negedge clk);
      bus.start  = 1'b0;
      bus.addr   = $urandom;
      bus.nwords = 16'($urandom);
   endtask

   task automatic run_job(input logic [31:0] a0, input int n, input int eb, input logic exp_err);
      int cyc;
      int nb;
      start_job(a0, n, eb);
      nb = burst_q.size();
      if (n == 0) begin
         check_value("zero_done", 64'(bus.done), 64'd1);
         check_value("zero_busy", 64'(bus.busy), 64'd0);
         check_value("zero_error", 64'(bus.error), 64'd0);
      end else begin
         check_value("busy_start", 64'(bus.busy), 64'd1);
         check_value("error_clear", 64'(bus.error), 64'd0);
         cyc = 0;
         while (!bus.done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
         end
         if (!bus.done) begin
            check_value("done_timeout", 64'd0, 64'd1);
            finish_test();
         end
         check_value("error_at_done", 64'(bus.error), 64'(exp_err));
         check_value("bursts_left", 64'(burst_q.size()), 64'd0);
         check_value("words_left", 64'(exp_q.size()), 64'd0);
      end
      @(negedge clk);
      check_value("done_pulse", 64'(bus.done), 64'd0);
      check_value("busy_after", 64'(bus.busy), 64'd0);
      if (n == 0) check_value("zero_no_svalid", 64'(seen_svalid), 64'd0);
      $display("job addr=%08h nwords=%0d error=%0b", a0, n, bus.error);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_busy"}, 64'(bus.busy), 64'd0);
      check_value({tag, "_done"}, 64'(bus.done), 64'd0);
      check_value({tag, "_error"}, 64'(bus.error), 64'd0);
      check_value({tag, "_s_valid"}, 64'(bus.s_valid), 64'd0);
      check_value({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
      check_value({tag, "_wr_length"}, 64'(bus.wr_length), 64'd0);
      check_value({tag, "_s_addr"}, 64'(bus.s_addr), 64'd0);
   endtask

   initial begin
      int cyc;
      int base;
      rst_n = 1'b0;
      bus.start  = 1'b0;
      bus.addr   = '0;
      bus.nwords = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      run_job(32'h0000_1000, 16, -1, 1'b0);
      run_job(32'h0000_0FF0, 8, -1, 1'b0);
      run_job(32'h0000_0000, 600, -1, 1'b0);
      run_job(32'h0000_0000, 0, -1, 1'b0);
      run_job(32'h0000_0000, 600, 1, 1'b1);
      run_job(32'h0000_0100, 5, -1, 1'b0);
      run_job(32'hFFFF_FFF8, 4, -1, 1'b0);
      run_job(32'h0000_0F00, 300, -1, 1'b0);

      // reset in the middle of a data phase
      base = beats_seen;
      start_job(32'h0000_2000, 600, -1);
      cyc = 0;
      while (beats_seen < base + 20 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      check_value("mid_data_reached", 64'(beats_seen >= base + 20), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_job(32'h0000_0040, 4, -1, 1'b0);

      finish_test();
   end
endmodule
